// File: rtl/parity_gen_serial_tx.sv
// ============================================================================
//  Module   : parity_gen_serial_tx
//  Brief    : Serial even-parity frame transmitter:
//             start(0), data LSB-first, parity, stop(1).
//             Each line bit is held for CLKS_PER_BIT clocks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module parity_gen_serial_tx #(
    parameter int DATA_W       = 3,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_out,
    output logic              busy,
    output logic              parity_out
);

    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            state_q,  state_d;
    logic [DATA_W-1:0] shreg_q,  shreg_d;
    logic [CYC_W-1:0]  cyc_q,    cyc_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              parity_q, parity_d;
    logic              busy_q,   busy_d;
    logic              tx_q,     tx_d;
    logic              bit_end;

    assign bit_end = (cyc_q == CYC_LAST);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cyc_d    = cyc_q;
        bitcnt_d = bitcnt_q;
        parity_d = parity_q;
        busy_d   = busy_q;

        if (state_q != ST_IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + CYC_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d  = in_data;
                    parity_d = ^in_data;
                    bitcnt_d = '0;
                    cyc_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bitcnt_d = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = ST_PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + BIT_ONE;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Line value is decoded from the next state so tx changes on the same edge as the state.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cyc_q    <= '0;
            bitcnt_q <= '0;
            parity_q <= 1'b0;
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cyc_q    <= cyc_d;
            bitcnt_q <= bitcnt_d;
            parity_q <= parity_d;
            busy_q   <= busy_d;
            tx_q     <= tx_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign parity_out = parity_q;

endmodule

`default_nettype wire

// File: tb/tb_parity_gen_serial_tx.sv
// ============================================================================
//  Module   : tb_parity_gen_serial_tx
//  Brief    : Scoreboard bench: the driver queues expected frames, a line
//             receiver rebuilds frames mid-bit and compares them.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_parity_gen_serial_tx;

    localparam int DW    = 3;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 3) * CPB;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic          tx_out;
    logic          busy;
    logic          parity_out;

    parity_gen_serial_tx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tx_out     (tx_out),
        .busy       (busy),
        .parity_out (parity_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
    } exp_t;

    exp_t exp_q[$];
    int   errors      = 0;
    int   checks      = 0;
    int   cyc         = 0;
    int   frames_sent = 0;
    int   frames_rx   = 0;
    int   aborts      = 0;
    bit   abort_flag  = 1'b0;
    bit   gap_mode    = 1'b0;
    int   last_start  = -1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) abort_flag = 1'b1;

    function automatic logic ref_parity(input logic [DW-1:0] w);
        return ($countones(w) % 2) == 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input logic [DW-1:0] w);
        exp_t e;
        e.data = w;
        e.par  = ref_parity(w);
        exp_q.push_back(e);
        frames_sent++;
    endtask

    // Returns #1 after the edge that accepted the word.
    task automatic wait_accept(input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 200) begin
                chk({nm, "_timeout"}, 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({nm, "_idle_timeout"}, 0, 1);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = w;
        expect_word(w);
        wait_accept("send");
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        @(negedge clk);
        chk("parity_out", int'(parity_out), int'(ref_parity(w)));
        chk("tx_low_cycle1", int'(tx_out), 0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, FRAME);
        chk("ready_after", int'(in_ready), 1);
        chk("parity_hold", int'(parity_out), int'(ref_parity(w)));
    endtask

    // Line receiver: detects the start bit, samples every bit mid-way.
    initial begin : receiver
        int            start_cyc;
        bit            ab;
        logic [DW+2:0] s;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_out === 1'b0) begin
                start_cyc  = cyc;
                abort_flag = 1'b0;
                ab         = 1'b0;
                s          = '0;
                if (gap_mode && last_start >= 0)
                    chk("frame_gap", start_cyc - last_start, FRAME + 1);
                last_start = start_cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < DW + 3; k++) begin
                    if (k > 0) repeat (CPB) @(negedge clk);
                    if (abort_flag) begin
                        ab = 1'b1;
                        break;
                    end
                    s[k] = tx_out;
                end
                if (ab) begin
                    aborts++;
                    last_start = -1;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    repeat (CPB - CPB / 2 - 1) @(negedge clk);
                    frames_rx++;
                    if (exp_q.size() == 0) begin
                        chk("frame_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_start", int'(s[0]), 0);
                        chk("frame_data", int'(s[DW:1]), int'(e.data));
                        chk("frame_parity", int'(s[DW+1]), int'(e.par));
                        chk("frame_even_ones", $countones(s[DW+1:1]) % 2, 0);
                        chk("frame_stop", int'(s[DW+2]), 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : driver
        logic [DW-1:0] w;
        int            n;
        bit            bad;

        // Reset and idle line
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({tx_out, in_ready, busy, parity_out}), 4'b1100);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_line", int'({tx_out, in_ready, busy}), 3'b110);
        end

        // Directed words
        send_word(3'b101);
        send_word(3'b111);
        send_word(3'b000);

        // Sweep with in_valid held high
        @(posedge clk);
        #1;
        last_start = -1;
        gap_mode   = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'(i);
            expect_word(DW'(i));
            wait_accept("sweep");
            if (i == 7) in_valid = 1'b0;
            @(negedge clk);
            chk("sweep_parity", int'(parity_out), int'(ref_parity(DW'(i))));
        end
        wait_idle("sweep");
        repeat (3) @(negedge clk);
        gap_mode = 1'b0;

        // Input activity while busy must be ignored
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 3'b010;
        expect_word(3'b010);
        wait_accept("busy_ign");
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
            in_data  = DW'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            chk("ready_while_busy", int'(in_ready), 0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        chk("parity_while_busy", int'(parity_out), int'(ref_parity(3'b010)));
        wait_idle("busy_ign");
        send_word(3'b100);

        // Randomized words with random gaps
        for (int i = 0; i < 12; i++) begin
            w = DW'($urandom);
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_data  = w;
            expect_word(w);
            wait_accept("rand");
            in_valid = 1'b0;
            @(negedge clk);
            chk("rand_parity", int'(parity_out), int'(ref_parity(w)));
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        wait_idle("rand");
        repeat (4) @(negedge clk);

        // Reset during the first data bit aborts the frame
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 3'b110;
        expect_word(3'b110);
        wait_accept("abort");
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", int'({tx_out, in_ready, busy, parity_out}), 4'b1100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ({tx_out, busy} !== 2'b10) bad = 1'b1;
        end
        chk("no_resume_after_reset", int'(bad), 0);
        send_word(3'b011);

        // Drain the scoreboard
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("aborted_frames", aborts, 1);
        chk("frames_received", frames_rx, frames_sent - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
